pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Parametrised program-counter and fetch-sequencing unit that replaces the plain PC register at the front of the pipeline.
- Holds the fetch PC and issues one outstanding request at a time to the instruction cache using a req/ready and rvalid handshake.
- Delivers each returned instruction with its PC to IF/ID through a one-entry skid buffer.
- Applies redirects (branch/jump/trap) and squashes the stale response that is still in flight when a redirect arrives.

Parameters:
- XLEN, 32, width of PC and addresses.
- ILEN, 32, instruction width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- INST_BYTES, 4, sequential PC increment.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low.
- stall  in  1  downstream not accepting; hold the delivered instruction and block new issue.
- redirect_valid  in  1  load redirect_pc this cycle; highest priority after reset.
- redirect_pc  in  XLEN  redirect target.
- imem_req  out  1  fetch request to the I-cache.
- imem_addr  out  XLEN  fetch address; equals pc_out.
- imem_ready  in  1  cache accepts the request this cycle.
- imem_rvalid  in  1  cache returns data this cycle.
- imem_rdata  in  ILEN  returned instruction.
- pc_out  out  XLEN  current fetch PC.
- inst_valid  out  1  inst_out/inst_pc valid to IF/ID.
- inst_out  out  ILEN  delivered instruction.
- inst_pc  out  XLEN  PC of inst_out.
- misalign_err  out  1  redirect target misaligned (optional feature only).

Behaviour:
- Reset (rst==0 at posedge):
  - pc_out=RESET_VECTOR; inst_valid=0; inst_out=0; inst_pc=0; misalign_err=0.
  - Skid buffer empty; state=ISSUE.
  - Reset overrides redirect and stall.
- States:
  - ISSUE: imem_req = !stall && !redirect_valid. On imem_req && imem_ready: req_pc<=pc_out; pc_out<=pc_out+INST_BYTES, wrapping mod 2^XLEN; go to WAIT. imem_rvalid is ignored in ISSUE (covers a stale response after reset).
  - WAIT: imem_req=0. On imem_rvalid with !stall: inst_out<=imem_rdata; inst_pc<=req_pc; inst_valid<=1; go to ISSUE. On imem_rvalid with stall: skid<=imem_rdata and req_pc; go to HOLD.
  - HOLD: imem_req=0. When !stall: skid moves to the outputs; inst_valid<=1; go to ISSUE.
  - DROP: imem_req=0. On imem_rvalid: data discarded; go to ISSUE.
- inst_valid:
  - When stall=1, inst_valid/inst_out/inst_pc hold.
  - When stall=0 and nothing is delivered that cycle, inst_valid<=0 (instruction consumed).
- Redirect (redirect_valid=1), regardless of stall:
  - pc_out<=redirect_pc; inst_valid<=0; skid cleared.
  - From WAIT with no rvalid: go to DROP.
  - From WAIT with rvalid in the same cycle: response discarded; go to ISSUE.
  - From ISSUE/HOLD: go to ISSUE. From DROP: stay in DROP.
- Latency: request accepted at cycle N; rvalid at cycle M>N gives inst_valid=1 at M+1 when not stalled. Back-to-back issue is possible on the cycle after delivery.
- Only one request is ever outstanding.

Optional Feature:
- PC_MISALIGN_CHK_EN defined:
  - A redirect with redirect_pc[1:0]!=0 loads {redirect_pc[XLEN-1:2],2'b00}.
  - misalign_err is registered and pulses high for exactly 1 cycle after such a redirect.
- PC_MISALIGN_CHK_EN undefined:
  - redirect_pc is loaded unchanged.
  - misalign_err is tied to 0.

Test Plan:
- Reset then sequential fetch: rst low 2 cycles, then high; imem_ready=1, rvalid 1 cycle after each accept, rdata=0x00000013 -> imem_addr 0x0, 0x4, 0x8; inst_pc 0x0, 0x4, 0x8 with inst_valid pulses.
- Stall during response: stall=1 at the cycle rvalid returns 0xDEADBEEF for PC 0x4 -> state HOLD, imem_req=0; stall released -> inst_out=0xDEADBEEF, inst_pc=0x4 one cycle later.
- Redirect while waiting: request for 0x8 outstanding, redirect_pc=0x100 -> DROP; the following rvalid is discarded (inst_valid stays 0); next imem_addr=0x100.
- Redirect coincident with rvalid in WAIT -> no inst_valid for that data; next request at redirect_pc.
- Wrap-around: redirect to 0xFFFFFFFC, accept -> pc_out=0x00000000.
- PC_MISALIGN_CHK_EN: redirect_pc=0x102 -> imem_addr=0x100, misalign_err=1 for exactly 1 cycle. Without the macro: imem_addr=0x102, misalign_err stays 0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - fetch PC with a single outstanding I-cache request, skid buffer and redirect squash
// Optional redirect alignment check enabled by PC_MISALIGN_CHK_EN.
module pc_fetch_unit #(
   parameter int              XLEN         = 32,
   parameter int              ILEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INST_BYTES   = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic            imem_rvalid,
   input  logic [ILEN-1:0] imem_rdata,
   output logic [XLEN-1:0] pc_out,
   output logic            inst_valid,
   output logic [ILEN-1:0] inst_out,
   output logic [XLEN-1:0] inst_pc,
   output logic            misalign_err
);

   typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD, ST_DROP} state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_pc_q, req_pc_d;
   logic [ILEN-1:0] skid_data_q, skid_data_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic            inst_valid_q, inst_valid_d;
   logic [ILEN-1:0] inst_out_q, inst_out_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic [XLEN-1:0] redirect_target;

`ifdef PC_MISALIGN_CHK_EN
   logic misalign_q, misalign_d;

   always_comb begin
      redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
      misalign_d      = redirect_valid && (redirect_pc[1:0] != 2'b00);
   end

   always_ff @(posedge clk) begin
      if (!rst) misalign_q <= 1'b0;
      else      misalign_q <= misalign_d;
   end

   assign misalign_err = misalign_q;
`else
   assign redirect_target = redirect_pc;
   assign misalign_err    = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      skid_data_d  = skid_data_q;
      skid_pc_d    = skid_pc_q;
      inst_valid_d = inst_valid_q;
      inst_out_d   = inst_out_q;
      inst_pc_d    = inst_pc_q;
      imem_req     = (state_q == ST_ISSUE) && !stall && !redirect_valid;

      // An unstalled consumer takes the current instruction unless a new one lands
      if (!stall) inst_valid_d = 1'b0;

      if (redirect_valid) begin
         pc_d         = redirect_target;
         inst_valid_d = 1'b0;
         skid_data_d  = '0;
         skid_pc_d    = '0;
         // A response still in flight must be swallowed before issuing again
         if ((state_q == ST_WAIT || state_q == ST_DROP) && !imem_rvalid) state_d = ST_DROP;
         else                                                             state_d = ST_ISSUE;
      end else begin
         case (state_q)
            ST_ISSUE: begin
               if (imem_req && imem_ready) begin
                  req_pc_d = pc_q;
                  pc_d     = pc_q + XLEN'(INST_BYTES);
                  state_d  = ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  if (!stall) begin
                     inst_out_d   = imem_rdata;
                     inst_pc_d    = req_pc_q;
                     inst_valid_d = 1'b1;
                     state_d      = ST_ISSUE;
                  end else begin
                     skid_data_d = imem_rdata;
                     skid_pc_d   = req_pc_q;
                     state_d     = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  inst_out_d   = skid_data_q;
                  inst_pc_d    = skid_pc_q;
                  inst_valid_d = 1'b1;
                  state_d      = ST_ISSUE;
               end
            end
            ST_DROP: begin
               if (imem_rvalid) state_d = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= ST_ISSUE;
         pc_q         <= RESET_VECTOR;
         req_pc_q     <= '0;
         skid_data_q  <= '0;
         skid_pc_q    <= '0;
         inst_valid_q <= 1'b0;
         inst_out_q   <= '0;
         inst_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         skid_data_q  <= skid_data_d;
         skid_pc_q    <= skid_pc_d;
         inst_valid_q <= inst_valid_d;
         inst_out_q   <= inst_out_d;
         inst_pc_q    <= inst_pc_d;
      end
   end

   assign imem_addr  = pc_q;
   assign pc_out     = pc_q;
   assign inst_valid = inst_valid_q;
   assign inst_out   = inst_out_q;
   assign inst_pc    = inst_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed and randomized checks of pc_fetch_unit against a transaction-level model
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] pc_out;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        misalign_err;

   pc_fetch_unit dut (
      .clk(clk), .rst(rst), .stall(stall),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .pc_out(pc_out), .inst_valid(inst_valid), .inst_out(inst_out),
      .inst_pc(inst_pc), .misalign_err(misalign_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Model: fetch PC, whether a request is in flight (and doomed), a parked instruction, the IF/ID view
   logic [31:0] m_pc;
   bit          m_busy, m_doomed, m_parked, m_acc;
   logic [31:0] m_tag, m_park_data, m_park_pc;
   logic        m_v, m_mis;
   logic [31:0] m_inst, m_ipc;
   int          cache_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_busy = 0; m_doomed = 0; m_parked = 0; m_acc = 0;
      m_tag = 0; m_park_data = 0; m_park_pc = 0;
      m_v = 0; m_mis = 0; m_inst = 0; m_ipc = 0;
   endtask

   task automatic check_regs(input string tag);
      chk({tag, ".pc_out"}, pc_out, m_pc);
      chk({tag, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, m_v});
      chk({tag, ".inst_out"}, inst_out, m_inst);
      chk({tag, ".inst_pc"}, inst_pc, m_ipc);
      chk({tag, ".misalign_err"}, {31'b0, misalign_err}, {31'b0, m_mis});
   endtask

   task automatic drive(input string tag, input logic s, input logic r, input logic [31:0] rp,
                        input logic rdy, input logic rv, input logic [31:0] rd);
      logic        exp_req;
      logic [31:0] tgt;
      stall = s; redirect_valid = r; redirect_pc = rp;
      imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
      #1;
      exp_req = !m_busy && !m_parked && !s && !r;
      chk({tag, ".imem_req"}, {31'b0, imem_req}, {31'b0, exp_req});
      chk({tag, ".imem_addr"}, imem_addr, m_pc);
      @(posedge clk);
      tgt = rp;
      m_mis = 0;
`ifdef PC_MISALIGN_CHK_EN
      if (rp[1:0] != 2'b00) tgt = rp & 32'hFFFF_FFFC;
      m_mis = r && (rp[1:0] != 2'b00);
`endif
      m_acc = 0;
      if (r) begin
         m_pc = tgt; m_v = 0; m_parked = 0;
         if (m_busy) begin
            if (rv) begin m_busy = 0; m_doomed = 0; end
            else m_doomed = 1;
         end
      end else begin
         if (!s) m_v = 0;
         if (exp_req && rdy) begin
            m_tag = m_pc; m_pc = m_pc + 32'd4; m_busy = 1; m_doomed = 0; m_acc = 1;
         end else if (m_busy && rv) begin
            if (!m_doomed) begin
               if (!s) begin m_v = 1; m_inst = rd; m_ipc = m_tag; end
               else begin m_parked = 1; m_park_data = rd; m_park_pc = m_tag; end
            end
            m_busy = 0; m_doomed = 0;
         end else if (m_parked && !s) begin
            m_v = 1; m_inst = m_park_data; m_ipc = m_park_pc; m_parked = 0;
         end
      end
      #1;
      check_regs(tag);
   endtask

   initial begin
      logic        s, r, rv;
      logic [31:0] rp;

      // Reset with redirect and stall asserted to show reset wins
      rst = 1'b0; stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
      chk("reset.pc_out", pc_out, 32'h0);
      chk("reset.inst_valid", {31'b0, inst_valid}, 32'h0);
      chk("reset.inst_out", inst_out, 32'h0);
      chk("reset.inst_pc", inst_pc, 32'h0);
      chk("reset.misalign_err", {31'b0, misalign_err}, 32'h0);

      // Sequential fetch 0x0, 0x4, 0x8
      for (int i = 0; i < 3; i++) begin
         drive("seq_acc", 0, 0, 0, 1, 0, 0);
         chk("seq.pc_after_accept", pc_out, 32'(i * 4 + 4));
         drive("seq_rsp", 0, 0, 0, 0, 1, 32'h13);
         chk("seq.inst_valid", {31'b0, inst_valid}, 32'h1);
         chk("seq.inst_pc", inst_pc, 32'(i * 4));
         chk("seq.inst_out", inst_out, 32'h13);
      end

      // Redirect to 0x4 then stall on the returning response
      drive("stall_redir", 0, 1, 32'h4, 0, 0, 0);
      drive("stall_acc", 0, 0, 0, 1, 0, 0);
      drive("stall_rsp", 1, 0, 0, 1, 1, 32'hDEADBEEF);
      chk("hold.inst_valid", {31'b0, inst_valid}, 32'h0);
      drive("stall_rel", 0, 0, 0, 1, 0, 0);
      chk("hold.inst_out", inst_out, 32'hDEADBEEF);
      chk("hold.inst_pc", inst_pc, 32'h4);
      chk("hold.inst_valid_rel", {31'b0, inst_valid}, 32'h1);

      // Redirect while waiting: stale response dropped
      drive("drop_acc", 0, 0, 0, 1, 0, 0);
      chk("drop.pc_after_accept", pc_out, 32'hC);
      drive("drop_redir", 0, 1, 32'h100, 1, 0, 0);
      drive("drop_stale", 0, 0, 0, 1, 1, 32'h55);
      chk("drop.inst_valid", {31'b0, inst_valid}, 32'h0);
      drive("drop_next", 0, 0, 0, 1, 0, 0);
      chk("drop.pc_next", pc_out, 32'h104);

      // Redirect coincident with rvalid in WAIT
      drive("coin_redir", 0, 1, 32'h200, 0, 1, 32'h77);
      chk("coin.inst_valid", {31'b0, inst_valid}, 32'h0);
      chk("coin.pc_out", pc_out, 32'h200);
      drive("coin_acc", 0, 0, 0, 1, 0, 0);
      drive("coin_rsp", 0, 0, 0, 0, 1, 32'h99);
      chk("coin.inst_pc", inst_pc, 32'h200);

      // Wrap-around
      drive("wrap_redir", 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      drive("wrap_acc", 0, 0, 0, 1, 0, 0);
      chk("wrap.pc_out", pc_out, 32'h0);
      drive("wrap_rsp", 0, 0, 0, 0, 1, 32'h11);
      chk("wrap.inst_pc", inst_pc, 32'hFFFF_FFFC);

      // Misaligned redirect target
      drive("mis_redir", 0, 1, 32'h102, 0, 0, 0);
`ifdef PC_MISALIGN_CHK_EN
      chk("mis.pc_out", pc_out, 32'h100);
      chk("mis.err_pulse", {31'b0, misalign_err}, 32'h1);
`else
      chk("mis.pc_out", pc_out, 32'h102);
      chk("mis.err_tied", {31'b0, misalign_err}, 32'h0);
`endif
      drive("mis_after", 0, 0, 0, 0, 0, 0);
      chk("mis.err_after", {31'b0, misalign_err}, 32'h0);

      // Randomized traffic; the cache answers each accepted request after 1..3 cycles
      cache_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         s  = ($urandom % 4) == 0;
         r  = ($urandom % 10) == 0;
         rp = $urandom;
         if (($urandom % 4) != 0) rp[1:0] = 2'b00;
         if (m_busy) begin
            rv = (cache_cnt == 0);
            if (cache_cnt != 0) cache_cnt--;
         end else begin
            rv = ($urandom % 8) == 0;
         end
         drive("rand", s, r, rp, 1'($urandom % 2), rv, $urandom);
         if (m_acc) cache_cnt = $urandom % 3;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
